// File: rtl/fpga_config_loader.sv
// Serial configuration loader: hunts for a sync word, shifts a fixed-length
// payload into a scan chain while running a CRC-8, then checks the trailing
// CRC byte. The user fabric is held in reset unless a frame has been loaded
// and verified.
module fpga_config_loader #(
  parameter int          CHAIN_LEN = 64,
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter logic [7:0]  CRC_POLY  = 8'h07
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_in,
  input  logic cfg_valid,
  input  logic cfg_abort,
  output logic chain_en,
  output logic chain_data,
  output logic fabric_rst,
  output logic busy,
  output logic done,
  output logic crc_err
);

  // One counter serves both the payload phase and the 8-bit CRC phase; it
  // is sized for the payload, which is always the longer of the two.
  localparam int                 CNT_W        = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   LAST_PAYLOAD = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]   LAST_CRC_BIT = CNT_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CRC   = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       sync_reg, sync_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       crc_reg, crc_next;
  logic [7:0]       rx_crc_reg, rx_crc_next;
  logic             chain_en_reg, chain_en_next;
  logic             chain_data_reg, chain_data_next;

  // Candidate values when the current bit is accepted; the FSM decides
  // which of them are actually committed.
  logic [7:0] sync_shift;
  logic [7:0] rx_crc_shift;
  logic [7:0] crc_step;
  logic       crc_fb;

  assign sync_shift   = {sync_reg[6:0], cfg_in};
  assign rx_crc_shift = {rx_crc_reg[6:0], cfg_in};
  assign crc_fb       = crc_reg[7] ^ cfg_in;
  assign crc_step     = {crc_reg[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);

  // State and datapath registers; reset abandons any partial load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      sync_reg       <= 8'h00;
      cnt_reg        <= '0;
      crc_reg        <= 8'h00;
      rx_crc_reg     <= 8'h00;
      chain_en_reg   <= 1'b0;
      chain_data_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sync_reg       <= sync_next;
      cnt_reg        <= cnt_next;
      crc_reg        <= crc_next;
      rx_crc_reg     <= rx_crc_next;
      chain_en_reg   <= chain_en_next;
      chain_data_reg <= chain_data_next;
    end
  end

  // Next-state logic: abort beats everything, idle cycles hold all state,
  // and each accepted bit advances exactly one phase of the frame.
  always_comb begin
    state_next      = state_reg;
    sync_next       = sync_reg;
    cnt_next        = cnt_reg;
    crc_next        = crc_reg;
    rx_crc_next     = rx_crc_reg;
    chain_en_next   = 1'b0;
    chain_data_next = 1'b0;

    if (cfg_abort) begin
      // The bit presented alongside an abort is dropped on purpose.
      state_next  = IDLE;
      sync_next   = 8'h00;
      cnt_next    = '0;
      crc_next    = 8'h00;
      rx_crc_next = 8'h00;
    end else if (cfg_valid) begin
      unique case (state_reg)
        IDLE, DONE, ERROR: begin
          // Matching on the shifted value lets the very next accepted bit
          // already count as payload bit 0.
          if (sync_shift == SYNC_WORD) begin
            state_next  = LOAD;
            sync_next   = 8'h00;
            cnt_next    = '0;
            crc_next    = 8'h00;
            rx_crc_next = 8'h00;
          end else begin
            sync_next = sync_shift;
          end
        end

        LOAD: begin
          // The sync register is frozen here, so payload that happens to
          // contain the sync pattern cannot restart framing.
          chain_en_next   = 1'b1;
          chain_data_next = cfg_in;
          crc_next        = crc_step;
          if (cnt_reg == LAST_PAYLOAD) begin
            state_next = CRC;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        CRC: begin
          rx_crc_next = rx_crc_shift;
          if (cnt_reg == LAST_CRC_BIT) begin
            state_next = (rx_crc_shift == crc_reg) ? DONE : ERROR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register so they are
  // correct during reset and in the first cycle of each state.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    crc_err    = 1'b0;
    fabric_rst = 1'b1;
    unique case (state_reg)
      LOAD, CRC: busy = 1'b1;
      DONE: begin
        done       = 1'b1;
        fabric_rst = 1'b0;
      end
      ERROR:   crc_err = 1'b1;
      default: ;
    endcase
  end

  assign chain_en   = chain_en_reg;
  assign chain_data = chain_data_reg;

endmodule

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 64, SHALL set the number of payload bits shifted into the configuration scan chain per load (legal range 8..4096).
REQ-002 Parameter SYNC_WORD, default 8'hA5, SHALL set the 8-bit frame-start pattern.
REQ-003 Parameter CRC_POLY, default 8'h07, SHALL set the CRC-8 polynomial (x^8 + x^2 + x + 1 by default).
REQ-004 clk  input  1  single clock for all logic; the scan chain is clocked by the same clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_in  input  1  serial configuration bit.
REQ-007 cfg_valid  input  1  cfg_in is sampled on each rising clk edge where cfg_valid=1.
REQ-008 cfg_abort  input  1  synchronous abort of any load in progress.
REQ-009 chain_en  output  1  scan-chain shift enable, connects to the chain's prog_en.
REQ-010 chain_data  output  1  scan-chain serial data, connects to the chain's prog_in.
REQ-011 fabric_rst  output  1  holds the user fabric in reset whenever no valid configuration is present.
REQ-012 busy  output  1  high in LOAD and CRC states.
REQ-013 done  output  1  high in DONE state.
REQ-014 crc_err  output  1  high in ERROR state.

Function
REQ-015 The loader SHALL implement a state machine with states IDLE, LOAD, CRC, DONE and ERROR.
REQ-016 In IDLE, DONE and ERROR, each accepted bit SHALL shift MSB-first into an 8-bit sync register; a match with SYNC_WORD in the cycle after that bit's acceptance SHALL move the state to LOAD.
REQ-017 On entry to LOAD, the sync register, bit counter and CRC register SHALL clear to 0; done and crc_err SHALL drop and fabric_rst SHALL rise in the same cycle.
REQ-018 In LOAD, every accepted bit SHALL produce chain_en=1 and chain_data=bit exactly one cycle later (registered, latency 1); chain_en SHALL be 0 in every other cycle.
REQ-019 In LOAD, every accepted bit SHALL also update a serial CRC-8 (init 8'h00, no reflection, no final XOR) using CRC_POLY.
REQ-020 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide; after exactly CHAIN_LEN accepted payload bits the state SHALL move to CRC, with no extra chain shifts.
REQ-021 In CRC, 8 accepted bits SHALL be collected MSB-first; on the 8th bit, the state SHALL go to DONE if the collected value equals the computed CRC, otherwise to ERROR.
REQ-022 In DONE, fabric_rst SHALL be 0; in every other state fabric_rst SHALL be 1.
REQ-023 Gaps (cfg_valid=0) of any length in any state SHALL stall progress without changing state or counters.
REQ-024 cfg_abort=1 SHALL force IDLE on the next edge from any state, clear all counters and the sync register, and set fabric_rst=1; a bit presented with cfg_valid in the same cycle SHALL be discarded.
REQ-025 A SYNC_WORD pattern appearing inside payload or CRC bits SHALL NOT restart framing.
REQ-026 A valid frame received in DONE or ERROR SHALL start a reload per REQ-016/REQ-017.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and all counters, the sync register and the CRC register SHALL be 0.
REQ-028 While rst=1, outputs SHALL be chain_en=0, chain_data=0, busy=0, done=0, crc_err=0 and fabric_rst=1.
REQ-029 Reset asserted mid-LOAD SHALL abandon the partial load; after release, the next frame SHALL load from bit 0.

Verification (CHAIN_LEN=8, defaults otherwise)
REQ-030 Stream A5, 01, 07 with continuous valid -> exactly 8 chain_en pulses with chain_data 0,0,0,0,0,0,0,1; done=1, fabric_rst=0 one cycle after the last CRC bit.
REQ-031 Stream A5, 01, 08 -> 8 chain_en pulses, then crc_err=1, done=0, fabric_rst=1.
REQ-032 Prefix bits 1,1,0 then A5, FF, F3 with random cfg_valid gaps -> sync found only after A5, done=1, the chain sees FF.
REQ-033 Stream A5 plus 4 payload bits, then cfg_abort -> IDLE, busy=0, fabric_rst=1; then A5, 01, 07 -> done=1.
REQ-034 rst pulse after 5 payload bits -> all outputs at reset values; a full frame afterwards yields exactly 8 chain_en pulses and done=1.
REQ-035 From DONE, stream A5, A5, 5A -> reload starts, and the payload byte A5 does not re-trigger sync; done or crc_err follows from the CRC-8 of A5.
